// File: rtl/xrf_pkg.sv
// Shared constants, write-port descriptor and hit-vector helper for the xrf_mp register file.
// The MAX_* bounds size the shared descriptor; instances must keep XLEN<=64, NREGS<=256, NWP<=8.
package xrf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  localparam int MAX_WP   = 8;
  localparam int MAX_AW   = 8;
  localparam int MAX_REGS = 1 << MAX_AW;
  localparam int MAX_XLEN = 64;

  typedef struct packed {
    logic                en;
    logic [MAX_AW-1:0]   addr;
    logic [MAX_XLEN-1:0] data;
  } xrf_wport_t;

  // One-hot OR of every enabled port's destination; duplicates collapse to one bit.
  function automatic logic [MAX_REGS-1:0] wport_hits(input xrf_wport_t [MAX_WP-1:0] wp);
    logic [MAX_REGS-1:0] h;
    h = '0;
    for (int w = 0; w < MAX_WP; w++) begin
      if (wp[w].en) h[wp[w].addr] = 1'b1;
    end
    return h;
  endfunction

endpackage

// File: rtl/xrf_mp_if.sv
// Issue/write-back bus of the multi-port register file: reads, write-back ports and allocation.
interface xrf_mp_if
  import xrf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRP   = 2,
  parameter int NWP   = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NRP*AW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rdata;
  logic [NRP-1:0]      rpend;
  logic [NWP-1:0]      wen;
  logic [NWP*AW-1:0]   waddr;
  logic [NWP*XLEN-1:0] wdata;
  logic                alloc_en;
  logic [AW-1:0]       alloc_rd;
  logic                alloc_rdy;
  logic [AW:0]         npend;

  modport master (
    output raddr, wen, waddr, wdata, alloc_en, alloc_rd,
    input  rdata, rpend, alloc_rdy, npend
  );

  modport slave (
    input  raddr, wen, waddr, wdata, alloc_en, alloc_rd,
    output rdata, rpend, alloc_rdy, npend
  );

endinterface

// File: rtl/xrf_scoreboard.sv
// Pending-bit scoreboard: tracks allocated destinations until write-back, counts them in npend.
module xrf_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [NREGS-1:0] wr_hit,
  input  logic             alloc_en,
  input  logic [AW-1:0]    alloc_rd,
  output logic             alloc_rdy,
  output logic [AW:0]      npend,
  output logic [NREGS-1:0] pending
);

  logic             acc;
  logic             inc;
  logic [NREGS-1:0] alloc_vec;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] pend_nxt;
  logic [AW:0]      n_clr;
  logic [AW:0]      npend_nxt;

  // Readiness depends only on the address and the writes, never on alloc_en.
  assign alloc_rdy = !pending[alloc_rd] || wr_hit[alloc_rd] || (alloc_rd == '0);
  assign acc       = alloc_en && alloc_rdy && (alloc_rd != '0);
  assign alloc_vec = acc ? (NREGS'(1) << alloc_rd) : '0;
  assign inc       = acc && !pending[alloc_rd];

  // A clear that is immediately re-allocated is not a net change.
  assign clr_vec  = wr_hit & pending & ~alloc_vec;
  assign pend_nxt = (pending & ~wr_hit) | alloc_vec;

  always_comb begin
    n_clr = '0;
    for (int r = 0; r < NREGS; r++) n_clr += (AW+1)'(clr_vec[r]);
  end

  assign npend_nxt = npend + (AW+1)'(inc) - n_clr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending <= '0;
      npend   <= '0;
    end else begin
      pending <= pend_nxt;
      npend   <= npend_nxt;
    end
  end

endmodule

// File: rtl/xrf_mp.sv
// Multi-port scalar register file with x0 hardwired, write arbitration, optional bypass
// and an integrated write-back scoreboard.
module xrf_mp
  import xrf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRP    = 2,
  parameter int NWP    = 1,
  parameter int BYPASS = 1
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  xrf_mp_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  xrf_wport_t [MAX_WP-1:0] wp;
  logic [MAX_REGS-1:0]     hit_wide;
  logic [NREGS-1:0]        wr_hit;
  logic [NREGS-1:0]        pend;
  logic                    unused_hit_hi;
  logic [XLEN-1:0]         mem [NREGS];

  // Writes to x0 are dropped here, so nothing downstream ever sees a hit on register 0.
  always_comb begin
    wp = '0;
    for (int w = 0; w < NWP; w++) begin
      wp[w].en   = bus.wen[w] && (bus.waddr[w*AW +: AW] != '0);
      wp[w].addr = MAX_AW'(bus.waddr[w*AW +: AW]);
      wp[w].data = MAX_XLEN'(bus.wdata[w*XLEN +: XLEN]);
    end
  end

  assign hit_wide      = wport_hits(wp);
  assign wr_hit        = hit_wide[NREGS-1:0];
  assign unused_hit_hi = ^hit_wide;

  // Later ports are assigned last, so the highest-index writer wins a collision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else begin
      for (int w = 0; w < NWP; w++) begin
        if (wp[w].en) mem[wp[w].addr[AW-1:0]] <= wp[w].data[XLEN-1:0];
      end
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] byp_data;
    logic            byp_hit;

    assign ra = bus.raddr[p*AW +: AW];

    always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      for (int w = 0; w < NWP; w++) begin
        if (BYPASS != 0 && wp[w].en && wp[w].addr[AW-1:0] == ra) begin
          byp_hit  = 1'b1;
          byp_data = wp[w].data[XLEN-1:0];
        end
      end
    end

    // Reset forces zero even if a write is being presented during reset.
    assign bus.rdata[p*XLEN +: XLEN] = (!i_rst_n || ra == '0) ? '0
                                     : byp_hit ? byp_data : mem[ra];
    assign bus.rpend[p] = i_rst_n && (ra != '0) && !byp_hit && pend[ra];
  end

  xrf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .wr_hit    (wr_hit),
    .alloc_en  (bus.alloc_en),
    .alloc_rd  (bus.alloc_rd),
    .alloc_rdy (bus.alloc_rdy),
    .npend     (bus.npend),
    .pending   (pend)
  );

endmodule

// File: tb/tb_xrf_mp.sv
// Directed and randomized bench for xrf_mp (dual write port, bypass on) against an array model.
module tb_xrf_mp;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NRP    = 2;
  localparam int NWP    = 2;
  localparam int BYPASS = 1;
  localparam int AW     = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xrf_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP)) bus ();

  xrf_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP), .BYPASS(BYPASS)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [XLEN-1:0] m_reg  [NREGS];
  bit              m_pend [NREGS];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit wr_to(input int a);
    for (int w = 0; w < NWP; w++)
      if (bus.wen[w] && int'(bus.waddr[w*AW +: AW]) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] exp_rdata(input int a);
    logic [XLEN-1:0] d;
    if (!rst_n || a == 0) return '0;
    d = m_reg[a];
    for (int w = 0; w < NWP; w++)
      if (BYPASS != 0 && bus.wen[w] && int'(bus.waddr[w*AW +: AW]) == a) d = bus.wdata[w*XLEN +: XLEN];
    return d;
  endfunction

  function automatic bit exp_rpend(input int a);
    if (!rst_n || a == 0) return 1'b0;
    if (BYPASS != 0 && wr_to(a)) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic bit exp_rdy();
    int rd = int'(bus.alloc_rd);
    return (rd == 0) || !m_pend[rd] || wr_to(rd);
  endfunction

  function automatic int exp_npend();
    int n = 0;
    for (int r = 0; r < NREGS; r++) n += int'(m_pend[r]);
    return n;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_reg[r]  = '0;
      m_pend[r] = 1'b0;
    end
  endtask

  task automatic idle();
    bus.raddr = '0; bus.wen = '0; bus.waddr = '0; bus.wdata = '0;
    bus.alloc_en = 1'b0; bus.alloc_rd = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    bus.raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int w, input int a, input logic [XLEN-1:0] d);
    bus.wen[w] = 1'b1;
    bus.waddr[w*AW +: AW] = AW'(a);
    bus.wdata[w*XLEN +: XLEN] = d;
  endtask

  task automatic set_alloc(input int a);
    bus.alloc_en = 1'b1;
    bus.alloc_rd = AW'(a);
  endtask

  task automatic check_outputs(input string tag);
    for (int p = 0; p < NRP; p++) begin
      int a = int'(bus.raddr[p*AW +: AW]);
      chk($sformatf("%s.rdata%0d", tag, p), 64'(bus.rdata[p*XLEN +: XLEN]), 64'(exp_rdata(a)));
      chk($sformatf("%s.rpend%0d", tag, p), 64'(bus.rpend[p]), 64'(exp_rpend(a)));
    end
    chk({tag, ".rdy"}, 64'(bus.alloc_rdy), 64'(exp_rdy()));
    chk({tag, ".npend"}, 64'(bus.npend), 64'(exp_npend()));
  endtask

  // Apply the current inputs to the model, then take the clock edge.
  task automatic clock_edge();
    bit rdy;
    int rd;
    if (rst_n) begin
      rdy = exp_rdy();
      rd  = int'(bus.alloc_rd);
      for (int w = 0; w < NWP; w++) begin
        int a = int'(bus.waddr[w*AW +: AW]);
        if (bus.wen[w] && a != 0) begin
          m_reg[a]  = bus.wdata[w*XLEN +: XLEN];
          m_pend[a] = 1'b0;
        end
      end
      if (bus.alloc_en && rdy && rd != 0) m_pend[rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    idle();
    set_wr(0, 9, 32'hCAFE0000);
    set_rd(0, 9);
    #12;
    check_outputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    @(posedge clk);
    #1;

    for (int r = 0; r < NREGS; r++) begin
      set_rd(0, r);
      set_rd(1, NREGS - 1 - r);
      #1;
      check_outputs($sformatf("rst_rd%0d", r));
    end

    idle();
    set_alloc(5);
    #1;
    check_outputs("alloc5");
    clock_edge();
    idle();
    set_rd(0, 5);
    #1;
    check_outputs("x5_pending");
    chk("x5_rpend_one", 64'(bus.rpend[0]), 64'd1);
    set_wr(0, 5, 32'hDEADBEEF);
    #1;
    check_outputs("x5_bypass");
    chk("x5_bypass_data", 64'(bus.rdata[XLEN-1:0]), 64'hDEADBEEF);
    clock_edge();
    idle();
    set_rd(1, 5);
    #1;
    check_outputs("x5_after");
    chk("x5_npend_zero", 64'(bus.npend), 64'd0);

    set_alloc(7);
    clock_edge();
    set_rd(0, 7);
    #1;
    check_outputs("x7_blocked");
    chk("x7_rdy_low", 64'(bus.alloc_rdy), 64'd0);
    clock_edge();
    check_outputs("x7_nochange");
    set_wr(1, 7, 32'h00C0FFEE);
    #1;
    check_outputs("x7_alloc_wr");
    clock_edge();
    idle();
    set_rd(0, 7);
    #1;
    check_outputs("x7_after");
    chk("x7_data", 64'(bus.rdata[XLEN-1:0]), 64'h00C0FFEE);
    chk("x7_npend_one", 64'(bus.npend), 64'd1);

    set_wr(0, 3, 32'h11);
    set_wr(1, 3, 32'h22);
    set_rd(1, 3);
    #1;
    check_outputs("x3_dual_byp");
    clock_edge();
    idle();
    set_rd(1, 3);
    #1;
    check_outputs("x3_dual");
    chk("x3_winner", 64'(bus.rdata[2*XLEN-1:XLEN]), 64'h22);

    set_wr(0, 0, 32'hFFFFFFFF);
    set_alloc(0);
    #1;
    check_outputs("x0_write");
    clock_edge();
    idle();
    #1;
    check_outputs("x0_after");
    chk("x0_data_zero", 64'(bus.rdata[XLEN-1:0]), 64'd0);

    for (int r = 1; r <= 3; r++) begin
      idle();
      set_alloc(r);
      clock_edge();
    end
    idle();
    set_rd(0, 1);
    set_rd(1, 2);
    #1;
    check_outputs("pre_reset");
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("mid_reset");
    chk("mid_reset_npend", 64'(bus.npend), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs("post_reset");

    for (int i = 0; i < 400; i++) begin
      idle();
      for (int p = 0; p < NRP; p++) set_rd(p, int'($urandom_range(0, 7)));
      for (int w = 0; w < NWP; w++)
        if ($urandom_range(0, 1) == 1) set_wr(w, int'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 1) == 1) set_alloc(int'($urandom_range(0, 7)));
      #1;
      check_outputs($sformatf("rnd%0d", i));
      clock_edge();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
